// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch sequencer's control, instruction-memory and decode-side signals.
// master is the sequencer side; slave is the memory/decode/execute environment.
interface fetch_sequencer_if;
  logic        start;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        halted;
  logic        fault;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  modport master (
    input  start, stall, redirect_valid, redirect_pc, imem_data,
    output imem_addr, instr_valid, instr_out, pc_out, halted, fault,
           fetch_count, stall_count
  );

  modport slave (
    output start, stall, redirect_valid, redirect_pc, imem_data,
    input  imem_addr, instr_valid, instr_out, pc_out, halted, fault,
           fetch_count, stall_count
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer feeding a single-entry fetch buffer; resolves J-type jumps at fetch time.
// Define FETCH_PERF_COUNT_EN to build the fetch/stall performance counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0004,
  parameter int unsigned IMEM_DEPTH  = 256,
  parameter logic [1:0]  J_TYPE_CODE = 2'b10
) (
  input logic            clock,
  input logic            reset,
  fetch_sequencer_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

  localparam logic [31:0] DEPTH_W = 32'(IMEM_DEPTH);

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] instr_q, instr_n;
  logic [31:0] pc_out_q, pc_out_n;
  logic        valid_q, valid_n;
  logic        fault_q, fault_n;
  logic [31:0] jump_offset;
  logic [31:0] next_pc;

  function automatic logic out_of_range(input logic [31:0] addr);
    return {2'b00, addr[31:2]} >= DEPTH_W;
  endfunction

  assign jump_offset = {{8{bus.imem_data[26]}}, bus.imem_data[26:3]};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      instr_q  <= '0;
      pc_out_q <= '0;
      valid_q  <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      instr_q  <= instr_n;
      pc_out_q <= pc_out_n;
      valid_q  <= valid_n;
      fault_q  <= fault_n;
    end
  end

  // Priority in FETCH: redirect squashes the buffer, then a stalled full buffer holds, else load.
  always_comb begin
    state_n  = state;
    pc_n     = pc;
    instr_n  = instr_q;
    pc_out_n = pc_out_q;
    valid_n  = valid_q;
    fault_n  = fault_q;
    next_pc  = (bus.imem_data[2:1] == J_TYPE_CODE) ? pc + jump_offset : pc + 32'd4;

    case (state)
      IDLE: begin
        if (bus.start) state_n = FETCH;
      end
      FETCH: begin
        if (bus.redirect_valid) begin
          pc_n    = bus.redirect_pc;
          valid_n = 1'b0;
          if (out_of_range(bus.redirect_pc)) begin
            fault_n = 1'b1;
            state_n = HALT;
          end
        end else if (!(bus.stall && valid_q)) begin
          instr_n  = bus.imem_data;
          pc_out_n = pc;
          valid_n  = 1'b1;
          if (bus.imem_data[0]) begin
            state_n = HALT;
          end else begin
            pc_n = next_pc;
            if (out_of_range(next_pc)) begin
              fault_n = 1'b1;
              state_n = HALT;
            end
          end
        end
      end
      HALT: begin
        if (bus.start) begin
          pc_n    = RESET_PC;
          valid_n = 1'b0;
          fault_n = 1'b0;
          state_n = FETCH;
        end else if (valid_q && !bus.stall) begin
          valid_n = 1'b0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.imem_addr   = pc;
  assign bus.instr_valid = valid_q;
  assign bus.instr_out   = instr_q;
  assign bus.pc_out      = pc_out_q;
  assign bus.halted      = (state == HALT);
  assign bus.fault       = fault_q;

`ifdef FETCH_PERF_COUNT_EN
  logic [31:0] fetch_cnt, stall_cnt;
  logic        cnt_load, cnt_stall, cnt_clear;

  assign cnt_load  = (state == FETCH) && !bus.redirect_valid && !(bus.stall && valid_q);
  assign cnt_stall = (state == FETCH) && !bus.redirect_valid && bus.stall && valid_q;
  assign cnt_clear = (state == HALT) && bus.start;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else if (cnt_clear) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (cnt_load)  fetch_cnt <= fetch_cnt + 32'd1;
      if (cnt_stall) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.fetch_count = fetch_cnt;
  assign bus.stall_count = stall_cnt;
`else
  assign bus.fetch_count = '0;
  assign bus.stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed scenarios plus a randomized run checked against a spec-level model of the fetch sequencer.
module tb_fetch_sequencer;
  logic clock;
  logic reset;
  int   checks;
  int   fails;

  logic [31:0] mem [0:255];

  fetch_sequencer_if bus ();

  fetch_sequencer dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational instruction memory; out-of-range addresses read as zero.
  always_comb begin
    if (bus.imem_addr[31:10] == 22'd0) bus.imem_data = mem[bus.imem_addr[9:2]];
    else                               bus.imem_data = 32'h0;
  end

  localparam int M_IDLE = 0, M_FETCH = 1, M_HALT = 2;
  int          m_state;
  logic [31:0] m_pc, m_instr, m_pcout, m_fc, m_sc;
  logic        m_valid, m_fault;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (a >= 32'd1024) return 32'h0;
    return mem[a[9:2]];
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_pc = 32'd4; m_instr = 0; m_pcout = 0;
    m_valid = 0; m_fault = 0; m_fc = 0; m_sc = 0;
  endtask

  // One clock edge of the spec's rules, using the inputs currently driven.
  task automatic model_step();
    logic [31:0] word, target;
    word = mem_read(m_pc);
    if (m_state == M_IDLE) begin
      if (bus.start) m_state = M_FETCH;
    end else if (m_state == M_FETCH) begin
      if (bus.redirect_valid) begin
        m_pc = bus.redirect_pc;
        m_valid = 0;
        if (bus.redirect_pc / 4 >= 256) begin m_fault = 1; m_state = M_HALT; end
      end else if (bus.stall && m_valid) begin
        m_sc = m_sc + 1;
      end else begin
        m_instr = word; m_pcout = m_pc; m_valid = 1; m_fc = m_fc + 1;
        if (word[0]) m_state = M_HALT;
        else begin
          if (word[2:1] == 2'b10) target = m_pc + 32'($signed(word[26:3]));
          else                    target = m_pc + 32'd4;
          m_pc = target;
          if (target / 4 >= 256) begin m_fault = 1; m_state = M_HALT; end
        end
      end
    end else begin
      if (bus.start) begin
        m_pc = 32'd4; m_valid = 0; m_fault = 0; m_state = M_FETCH; m_fc = 0; m_sc = 0;
      end else if (m_valid && !bus.stall) m_valid = 0;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs();
    bus.start = 0; bus.stall = 0; bus.redirect_valid = 0; bus.redirect_pc = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load_linear();
    mem[0] = 32'h0;
    for (int i = 1; i < 256; i++) mem[i] = (32'(i) << 8) | (((i & 1) != 0) ? 32'h2 : 32'h0);
  endtask

  task automatic start_pulse();
    bus.start = 1; tick(); bus.start = 0;
  endtask

  task automatic test_reset();
    load_linear();
    do_reset();
    checks++; if (bus.instr_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.instr_valid); end
    checks++; if (bus.pc_out !== 32'h0 || bus.instr_out !== 32'h0) begin fails++; $display("[TB] FAIL reset_buf: got pc_out %h instr %h expected 0 0", bus.pc_out, bus.instr_out); end
    checks++; if (bus.halted !== 1'b0 || bus.fault !== 1'b0) begin fails++; $display("[TB] FAIL reset_flags: got halted %b fault %b expected 0 0", bus.halted, bus.fault); end
    checks++; if (bus.imem_addr !== 32'd4) begin fails++; $display("[TB] FAIL reset_addr: got %h expected 4", bus.imem_addr); end
    checks++; if (bus.fetch_count !== 32'd0 || bus.stall_count !== 32'd0) begin fails++; $display("[TB] FAIL reset_counts: got %0d %0d expected 0 0", bus.fetch_count, bus.stall_count); end
  endtask

  task automatic test_sequential();
    load_linear();
    do_reset();
    start_pulse();
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'd4) begin fails++; $display("[TB] FAIL seq_first: got valid %b addr %h expected 0 4", bus.instr_valid, bus.imem_addr); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      checks++;
      if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'(4 * i) || bus.instr_out !== mem[i]) begin
        fails++; $display("[TB] FAIL seq_load%0d: got valid %b pc %h instr %h expected 1 %h %h", i, bus.instr_valid, bus.pc_out, bus.instr_out, 32'(4 * i), mem[i]);
      end
    end
  endtask

  task automatic test_jump();
    logic [31:0] exp_pc [7];
    exp_pc = '{32'd4, 32'd8, 32'd12, 32'd16, 32'd12, 32'd16, 32'd12};
    load_linear();
    mem[4] = 32'h07FF_FFE4;
    do_reset();
    start_pulse();
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (bus.pc_out !== exp_pc[i] || bus.instr_valid !== 1'b1) begin
        fails++; $display("[TB] FAIL jump_step%0d: got pc %h valid %b expected %h 1", i, bus.pc_out, bus.instr_valid, exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    logic [31:0] exp_sc, exp_fc;
    load_linear();
    do_reset();
    start_pulse();
    tick(); tick();
    bus.stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.pc_out !== 32'd8 || bus.instr_out !== mem[2] || bus.instr_valid !== 1'b1) begin
        fails++; $display("[TB] FAIL stall_hold%0d: got pc %h instr %h expected 8 %h", i, bus.pc_out, bus.instr_out, mem[2]);
      end
    end
    bus.stall = 0;
    tick();
    checks++; if (bus.pc_out !== 32'd12) begin fails++; $display("[TB] FAIL stall_release: got %h expected c", bus.pc_out); end
`ifdef FETCH_PERF_COUNT_EN
    exp_sc = 3; exp_fc = 3;
`else
    exp_sc = 0; exp_fc = 0;
`endif
    checks++; if (bus.stall_count !== exp_sc || bus.fetch_count !== exp_fc) begin fails++; $display("[TB] FAIL stall_counts: got %0d %0d expected %0d %0d", bus.stall_count, bus.fetch_count, exp_sc, exp_fc); end
  endtask

  task automatic test_redirect();
    load_linear();
    do_reset();
    start_pulse();
    tick();
    bus.redirect_valid = 1; bus.redirect_pc = 32'd32; bus.stall = 1;
    tick();
    checks++; if (bus.instr_valid !== 1'b0 || bus.imem_addr !== 32'd32) begin fails++; $display("[TB] FAIL redirect_squash: got valid %b addr %h expected 0 20", bus.instr_valid, bus.imem_addr); end
    clear_inputs();
    tick();
    checks++; if (bus.instr_valid !== 1'b1 || bus.pc_out !== 32'd32 || bus.instr_out !== mem[8]) begin fails++; $display("[TB] FAIL redirect_target: got valid %b pc %h expected 1 20", bus.instr_valid, bus.pc_out); end
  endtask

  task automatic test_stop();
    load_linear();
    mem[5] = 32'h0000_1001;
    do_reset();
    start_pulse();
    for (int i = 0; i < 5; i++) tick();
    checks++; if (bus.pc_out !== 32'd20 || bus.instr_valid !== 1'b1 || bus.halted !== 1'b1) begin fails++; $display("[TB] FAIL stop_deliver: got pc %h valid %b halted %b expected 14 1 1", bus.pc_out, bus.instr_valid, bus.halted); end
    bus.stall = 1;
    tick(); tick();
    checks++; if (bus.pc_out !== 32'd20 || bus.instr_valid !== 1'b1 || bus.halted !== 1'b1) begin fails++; $display("[TB] FAIL stop_hold: got pc %h valid %b halted %b expected 14 1 1", bus.pc_out, bus.instr_valid, bus.halted); end
    bus.stall = 0;
    tick();
    checks++; if (bus.instr_valid !== 1'b0 || bus.halted !== 1'b1) begin fails++; $display("[TB] FAIL stop_consume: got valid %b halted %b expected 0 1", bus.instr_valid, bus.halted); end
    bus.start = 1; bus.redirect_valid = 1; bus.redirect_pc = 32'd64;
    tick();
    clear_inputs();
    checks++; if (bus.halted !== 1'b0 || bus.fault !== 1'b0 || bus.imem_addr !== 32'd4) begin fails++; $display("[TB] FAIL stop_restart: got halted %b fault %b addr %h expected 0 0 4", bus.halted, bus.fault, bus.imem_addr); end
    tick();
    checks++; if (bus.pc_out !== 32'd4 || bus.instr_valid !== 1'b1) begin fails++; $display("[TB] FAIL stop_refetch: got pc %h valid %b expected 4 1", bus.pc_out, bus.instr_valid); end
  endtask

  task automatic test_fault();
    load_linear();
    do_reset();
    start_pulse();
    tick();
    bus.redirect_valid = 1; bus.redirect_pc = 32'd1024;
    tick();
    clear_inputs();
    checks++; if (bus.fault !== 1'b1 || bus.halted !== 1'b1 || bus.instr_valid !== 1'b0) begin fails++; $display("[TB] FAIL fault_set: got fault %b halted %b valid %b expected 1 1 0", bus.fault, bus.halted, bus.instr_valid); end
    #2 reset = 1;
    #1;
    checks++; if (bus.fault !== 1'b0 || bus.halted !== 1'b0 || bus.imem_addr !== 32'd4) begin fails++; $display("[TB] FAIL fault_async_reset: got fault %b halted %b addr %h expected 0 0 4", bus.fault, bus.halted, bus.imem_addr); end
    reset = 0;
    tick();
    start_pulse();
    tick(); tick();
    #2 reset = 1;
    #1;
    checks++; if (bus.instr_valid !== 1'b0 || bus.pc_out !== 32'h0 || bus.instr_out !== 32'h0 || bus.imem_addr !== 32'd4) begin fails++; $display("[TB] FAIL midfetch_reset: got valid %b pc %h instr %h addr %h expected 0 0 0 4", bus.instr_valid, bus.pc_out, bus.instr_out, bus.imem_addr); end
    reset = 0;
    tick();
  endtask

  task automatic test_random();
    logic [31:0] w, exp_fc, exp_sc;
    int r;
    mem[0] = 32'h0;
    for (int i = 1; i < 256; i++) begin
      r = int'($urandom_range(0, 99));
      w = $urandom;
      if (r < 4) w[0] = 1'b1;
      else if (r < 22) begin
        w = {5'b0, 24'($signed(int'($urandom_range(0, 40)) - 20) * 4 + ((r == 5) ? 1 : 0)), 2'b10, 1'b0};
      end else begin
        w[0] = 1'b0;
        if (w[2:1] == 2'b10) w[2:1] = 2'b01;
      end
      mem[i] = w;
    end
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bus.start = ($urandom_range(0, 15) == 0);
      bus.stall = ($urandom_range(0, 3) == 0);
      bus.redirect_valid = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 4) == 0) bus.redirect_pc = 32'($urandom_range(0, 300)) * 4 + 32'($urandom_range(0, 3));
      else                           bus.redirect_pc = 32'($urandom_range(0, 255)) * 4;
      model_step();
      tick();
`ifdef FETCH_PERF_COUNT_EN
      exp_fc = m_fc; exp_sc = m_sc;
`else
      exp_fc = 0; exp_sc = 0;
`endif
      checks++;
      if (bus.instr_valid !== m_valid || bus.pc_out !== m_pcout || bus.instr_out !== m_instr) begin
        fails++; $display("[TB] FAIL rand_buf cyc %0d: got %b %h %h expected %b %h %h", cyc, bus.instr_valid, bus.pc_out, bus.instr_out, m_valid, m_pcout, m_instr);
      end
      checks++;
      if (bus.imem_addr !== m_pc || bus.halted !== (m_state == M_HALT) || bus.fault !== m_fault) begin
        fails++; $display("[TB] FAIL rand_ctrl cyc %0d: got addr %h halted %b fault %b expected %h %b %b", cyc, bus.imem_addr, bus.halted, bus.fault, m_pc, (m_state == M_HALT), m_fault);
      end
      checks++;
      if (bus.fetch_count !== exp_fc || bus.stall_count !== exp_sc) begin
        fails++; $display("[TB] FAIL rand_counts cyc %0d: got %0d %0d expected %0d %0d", cyc, bus.fetch_count, bus.stall_count, exp_fc, exp_sc);
      end
    end
    clear_inputs();
  endtask

  initial begin
    checks = 0;
    fails  = 0;
    reset  = 1'b1;
    clear_inputs();
    load_linear();
    #2;
    $display("[TB] starting fetch_sequencer checks");
    test_reset();
    test_sequential();
    test_jump();
    test_stall();
    test_redirect();
    test_stop();
    test_fault();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program counter sequencer for the instruction memory; drives its address bus and registers the returned word into a single-entry fetch buffer for decode.
- Resolves J-type jumps at fetch time.
- Honours decode backpressure and execute-stage redirects.
- Halts on the Stop bit or on an out-of-range PC.
- Sits between the instruction memory (combinational read) and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0004, PC loaded on reset and on restart (word 1; word 0 is the null word).
- IMEM_DEPTH, 256, number of 32-bit words in instruction memory; PC word index >= IMEM_DEPTH is a fault.
- J_TYPE_CODE, 2'b10, value of Type field [2:1] that marks a J-type instruction.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  pulse; begins fetching from IDLE or HALT.
- stall  in  1  decode cannot accept; hold the buffer.
- redirect_valid  in  1  execute-stage branch taken.
- redirect_pc  in  32  byte address of the branch target.
- imem_addr  out  32  byte address to the instruction memory address bus.
- imem_data  in  32  instruction word, valid in the same cycle as imem_addr.
- instr_valid  out  1  fetch buffer holds a valid instruction.
- instr_out  out  32  buffered instruction.
- pc_out  out  32  byte address of instr_out.
- halted  out  1  sequencer is in HALT.
- fault  out  1  sticky; set when a fetch address is out of range.

Behaviour:
- Reset (async, any state, mid-fetch included):
  - state=IDLE, pc=RESET_PC.
  - instr_valid=0, instr_out=0, pc_out=0, halted=0, fault=0.
  - imem_addr=pc continuously (combinational).
- States: IDLE, FETCH, HALT.
- IDLE:
  - No loads.
  - start -> FETCH next edge; the first fetch is of RESET_PC.
- FETCH: each cycle, evaluate in priority order:
  1. redirect_valid:
     - pc<=redirect_pc; instr_valid<=0 (squash, stall ignored).
     - If redirect_pc[31:2] >= IMEM_DEPTH: fault<=1, state<=HALT.
  2. stall && instr_valid: hold pc, instr_out, pc_out and instr_valid.
  3. Otherwise load the buffer:
     - instr_out<=imem_data, pc_out<=pc, instr_valid<=1.
     - Next pc:
       - If imem_data[0] (Stop)=1: state<=HALT; pc unchanged.
       - Else if imem_data[2:1]==J_TYPE_CODE: pc<=pc + sign-extend(imem_data[26:3]) (byte offset, 32-bit wrap).
       - Else pc<=pc+4 (32-bit wrap).
     - If the computed next pc[31:2] >= IMEM_DEPTH and Stop=0: fault<=1, state<=HALT (buffer still loaded).
  - A pc whose low bits [1:0] are not 00 is not a fault; the low bits are carried in imem_addr unchanged.
- HALT:
  - halted=1; no loads.
  - instr_valid stays 1 until consumed (first cycle with stall=0), then clears.
  - redirect_valid is ignored.
  - start -> pc<=RESET_PC, instr_valid<=0, fault<=0, halted<=0, state<=FETCH.
- Latency:
  - imem_addr to instr_valid: 1 cycle.
  - Sustained throughput: 1 instruction/cycle with stall=0.
  - Redirect bubble: 1 cycle.
- Handshake: decode consumes on any edge where instr_valid=1 and stall=0.
- Simultaneous events:
  - redirect+stall: redirect wins.
  - start while in FETCH: ignored.
  - start+redirect in HALT: start wins.

Optional Feature:
- Macro: FETCH_PERF_COUNT_EN.
- Enabled:
  - Adds outputs fetch_count[31:0] (increments per buffer load) and stall_count[31:0] (increments per FETCH cycle where stall && instr_valid).
  - Both counters are cleared by reset and by restart from HALT, and wrap at 2^32.
- Disabled: both ports are present and tied to 0; no counter flops are synthesized.

Test Plan:
- Reset, start; memory word1=ADDI (Stop=0, Type=I), word2=ADDI, word3=ADD -> pc_out sequence 4,8,12 on consecutive cycles; instr_valid=1 from the 2nd cycle after start.
- J-type at pc 16 with imm24=-4 -> next pc_out=12 (16-4); a following non-jump -> pc_out=16.
- stall held 3 cycles while pc_out=8 -> instr_out/pc_out frozen; after release, pc_out=12 the next cycle; stall_count=3 with FETCH_PERF_COUNT_EN.
- redirect_valid with redirect_pc=32 and stall=1 in the same cycle -> instr_valid=0 next cycle, then pc_out=32.
- Word at pc 20 has Stop=1 -> pc_out=20 delivered, halted=1, no further fetches; start -> restart at pc_out=4, fault=0.
- redirect_pc=1024 (IMEM_DEPTH=256) -> fault=1, halted=1; assert reset mid-FETCH -> all outputs return to reset values immediately (asynchronously).
